// File: rtl/serie_paralelo.sv
// serie_paralelo: serial-to-parallel receiver for the ADC test path.
//   Samples one bit of entrada_serie on each cycle where bit_en is high and
//   builds an N_BITS word LSB-first: bit k of a frame goes to
//   datos_paralelo[k]. The word is handed downstream through a held-valid /
//   read-acknowledge handshake.
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   entrada_serie  serial data bit
//   bit_en         sample strobe; entrada_serie and inicio are ignored while low
//   inicio         frame start; marks bit 0 of a frame (only counts with bit_en)
//   leer           consumer read acknowledge; clears dato_listo
//   datos_paralelo last complete word (registered)
//   dato_listo     word available, held until leer
//   ocupado        high while a frame is being assembled
//   error_overrun  sticky overrun flag
// Optional feature: define SERIE_PARALELO_OVERRUN_EN to make error_overrun
//   latch when a word completes while the previous one is still unread.
//   If the macro is undefined, error_overrun is tied low.
module serie_paralelo #(
  parameter int N_BITS = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              entrada_serie,
  input  logic              bit_en,
  input  logic              inicio,
  input  logic              leer,
  output logic [N_BITS-1:0] datos_paralelo,
  output logic              dato_listo,
  output logic              ocupado,
  output logic              error_overrun
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  // The last bit is never stored here; it goes straight into datos_paralelo.
  logic [N_BITS-2:0] sr;
  logic [CNT_W-1:0]  cnt;
  logic              start, shift, last;

  // inicio is honoured in either state: in SHIFT it resyncs onto a new frame.
  assign start = bit_en & inicio;
  assign shift = bit_en & ~inicio & (state == SHIFT);
  assign last  = shift & (cnt == CNT_W'(N_BITS-1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ocupado = (state == SHIFT);
  end

  // Shift register and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (start) begin
      // Any partial word is discarded on a (re)start.
      sr    <= '0;
      sr[0] <= entrada_serie;
      cnt   <= CNT_W'(1);
    end else if (shift) begin
      if (last) begin
        cnt <= '0;
      end else begin
        sr[cnt] <= entrada_serie;  // cnt < N_BITS-1 on this path
        cnt     <= cnt + CNT_W'(1);
      end
    end
  end

  // Output word and handshake. A completion takes priority over leer, so a
  // word finishing on the same edge as a read stays flagged as available.
  always_ff @(posedge clk) begin
    if (reset) begin
      datos_paralelo <= '0;
      dato_listo     <= 1'b0;
    end else if (last) begin
      datos_paralelo <= {entrada_serie, sr};
      dato_listo     <= 1'b1;
    end else if (leer) begin
      dato_listo     <= 1'b0;
    end
  end

`ifdef SERIE_PARALELO_OVERRUN_EN
  // Overrun: a new word lands while the old one is unread and not being read
  // on this edge. Only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)                           error_overrun <= 1'b0;
    else if (last && dato_listo && !leer) error_overrun <= 1'b1;
  end
`else
  assign error_overrun = 1'b0;
`endif

endmodule
